dac_sample_scheduler: RTL
=========================

Name: dac_sample_scheduler

Overview:
Paces a bursty sample stream from the TX modem/FIR into the AD5541 AXI-Stream DAC sink at a fixed programmable sample rate.
Buffers input in a small FIFO and primes it before keying PTT. Fills underruns with a midscale code and sends a midscale tail after end-of-burst.
Sits between the TX FIR output and the DAC sink, and drives the radio PTT line.

Parameters:
FIFO_DEPTH, 16, FIFO entries; power of 2, minimum 4.
RATE_DIV, 100, clk cycles per output sample; minimum 16. Default gives 1 MSPS at 100 MHz.
PRIME_LEVEL, 8, FIFO level required before RUN starts; range 1..FIFO_DEPTH.
TAIL_TICKS, 32, number of IDLE_CODE samples sent after the last sample of a burst; minimum 1.
IDLE_CODE, 16'h8000, midscale code used for underrun fill and tail.

Ports:
clk  in  1  fabric clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
enable  in  1  scheduler enable; low aborts any burst
s_axis_tdata  in  16  sample from FIR
s_axis_tvalid  in  1  input valid
s_axis_tlast  in  1  last sample of burst
s_axis_tready  out  1  high when FIFO not full
m_axis_tdata  out  16  sample to DAC sink
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  DAC sink ready
ptt  out  1  transmitter key
underrun_pulse  out  1  one-cycle pulse per underrun fill
late_pulse  out  1  one-cycle pulse when a pending output word is overwritten
underrun_count  out  16  saturating underrun counter
state_o  out  2  current state, for debug

Behaviour:
Reset (async, rst_n low) values:
- All outputs 0, except m_axis_tdata = IDLE_CODE.
- state_o = IDLE, FIFO empty, rate counter 0.
Input handshake:
- s_axis_tready = !fifo_full, registered from FIFO state. It is independent of scheduler state.
- A write happens when tvalid && tready. Each FIFO entry stores {tlast, tdata}.
- Writes are ignored while enable is low or during flush.
Rate counter:
- Counts 0..RATE_DIV-1 only in RUN and DRAIN; it is held at 0 otherwise.
- tick = (cnt == RATE_DIV-1). The first tick occurs RATE_DIV cycles after RUN is entered.
Output handshake:
- On tick, the selected word is loaded into the output register and m_axis_tvalid goes high on the next cycle.
- m_axis_tvalid clears on m_axis_tready.
- If tick fires while m_axis_tvalid is still high, the new word overwrites the pending one and late_pulse fires.
- Simultaneous pop and push at a non-empty FIFO leaves the level unchanged.
States:
- IDLE: ptt=0. When enable && fifo_level>=1, go to PRIME.
- PRIME: ptt=1. Go to RUN when fifo_level>=PRIME_LEVEL, or when any stored entry has tlast set (short burst).
- RUN: ptt=1. On tick:
  - FIFO non-empty: pop and send. If the popped tlast=1, go to DRAIN with tail_cnt=TAIL_TICKS.
  - FIFO empty: send IDLE_CODE, pulse underrun_pulse, increment underrun_count (saturates at 16'hFFFF). Stay in RUN.
- DRAIN: ptt=1. On tick, send IDLE_CODE and decrement tail_cnt. After the tick that sends the last tail word (tail_cnt reaches 0), go to IDLE. ptt drops once that word has been accepted (m_axis_tvalid low).
Abort:
- enable low in PRIME or RUN: flush FIFO in one cycle, go to DRAIN with tail_cnt=TAIL_TICKS.
- enable low in DRAIN: the tail continues.
- underrun_count clears only on reset.

Optional Feature:
DAC_SCHED_TWOS_COMP_EN
- Defined: input samples are signed two's complement. Bit 15 is inverted at the output register to produce AD5541 straight binary. IDLE_CODE is not inverted.
- Undefined: samples pass through unchanged.

Decomposition:
Package dac_sched_pkg contains:
- state encoding: IDLE=0, PRIME=1, RUN=2, DRAIN=3
- default IDLE_CODE
- FIFO entry width (17)
Sub-module dac_sched_fifo: synchronous FIFO with level output, a flush input and a tlast-present flag (count of stored tlast entries > 0).

Test Plan:
1. Push 20 samples 0x1000..0x1013 with tlast on the last one; RATE_DIV=100, sink always ready.
   -> ptt rises the cycle after PRIME is entered; outputs are exactly 100 cycles apart, in order; then 32 words of 0x8000; then ptt=0 and state IDLE.
2. Push 3 samples with tlast, PRIME_LEVEL=8.
   -> RUN starts on the tlast condition; 3 data words, then 32 tail words; underrun_count stays 0.
3. Push 8 samples without tlast, then stall input for 5 ticks.
   -> 8 data words, then 5 words of 0x8000; 5 underrun_pulses; underrun_count=5; state remains RUN.
4. Hold m_axis_tready low for 150 cycles during RUN.
   -> one late_pulse; the first word is overwritten by the second; no FIFO entry is lost beyond that word.
5. Drop enable mid-RUN with 10 entries queued.
   -> FIFO level 0 next cycle; 32 tail words; ptt=0; s_axis_tready=1.
6. Assert rst_n low mid-DRAIN.
   -> ptt, m_axis_tvalid and the pulse outputs go 0 immediately; m_axis_tdata=0x8000; underrun_count=0.
   With DAC_SCHED_TWOS_COMP_EN defined: input 0x0000 -> output 0x8000; input 0xFFFF -> output 0x7FFF.

Source files
------------

// File: rtl/dac_sched_pkg.sv
// Shared types and helpers for the DAC sample scheduler.
// DAC_SCHED_TWOS_COMP_EN selects signed input samples converted to AD5541 straight binary.
package dac_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam logic [15:0] DEFAULT_IDLE_CODE = 16'h8000;
    localparam int unsigned ENTRY_W           = 17;

    // Applied to FIFO data only; fill and tail codes bypass this.
    function automatic logic [15:0] to_dac_code(input logic [15:0] sample);
`ifdef DAC_SCHED_TWOS_COMP_EN
        return {~sample[15], sample[14:0]};
`else
        return sample;
`endif
    endfunction

endpackage

// File: rtl/dac_sched_fifo.sv
// Synchronous FIFO of {tlast, tdata} entries with level, single-cycle flush,
// a registered not-full flag and a flag for any stored tlast entry.
module dac_sched_fifo
    import dac_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [ENTRY_W-1:0]       wr_data,
    input  logic                     rd_en,
    output logic [ENTRY_W-1:0]       rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     not_full,
    output logic                     last_present
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d, last_cnt_q, last_cnt_d;
    logic          not_full_q, not_full_d;
    logic          push, pop, push_last, pop_last;

    always_comb begin
        push       = wr_en && not_full_q;
        pop        = rd_en && (level_q != '0);
        push_last  = push && wr_data[ENTRY_W-1];
        pop_last   = pop && rd_data[ENTRY_W-1];
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        last_cnt_d = last_cnt_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            last_cnt_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            case ({push_last, pop_last})
                2'b10:   last_cnt_d = last_cnt_q + 1'b1;
                2'b01:   last_cnt_d = last_cnt_q - 1'b1;
                default: last_cnt_d = last_cnt_q;
            endcase
        end
        // Looking at the next level keeps the registered ready exact, never one write late.
        not_full_d = (level_d != FULL_LEVEL);
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            last_cnt_q <= '0;
            not_full_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            last_cnt_q <= last_cnt_d;
            not_full_q <= not_full_d;
        end
    end

    assign rd_data      = mem[rd_ptr_q];
    assign level        = level_q;
    assign empty        = (level_q == '0);
    assign not_full     = not_full_q;
    assign last_present = (last_cnt_q != '0);

endmodule

// File: rtl/dac_sample_scheduler.sv
// Paces a bursty sample stream into the DAC sink at a fixed rate and keys PTT.
// Build option DAC_SCHED_TWOS_COMP_EN: treat input samples as two's complement.
module dac_sample_scheduler
    import dac_sched_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned RATE_DIV    = 100,
    parameter int unsigned PRIME_LEVEL = 8,
    parameter int unsigned TAIL_TICKS  = 32,
    parameter logic [15:0] IDLE_CODE   = DEFAULT_IDLE_CODE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        ptt,
    output logic        underrun_pulse,
    output logic        late_pulse,
    output logic [15:0] underrun_count,
    output logic [1:0]  state_o
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CW = $clog2(RATE_DIV);
    localparam int unsigned TW = $clog2(TAIL_TICKS + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(RATE_DIV - 1);
    localparam logic [TW-1:0] TAIL_INIT = TW'(TAIL_TICKS);
    localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME_LEVEL);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [TW-1:0]       tail_q, tail_d;
    logic [15:0]         out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                underrun_q, underrun_d;
    logic                late_q, late_d;
    logic [15:0]         urun_cnt_q, urun_cnt_d;
    logic                ptt_q, ptt_d;
    logic                pacing, tick, load;

    logic                fifo_wr, fifo_rd, fifo_flush;
    logic [ENTRY_W-1:0]  fifo_rdata;
    logic [LW-1:0]       fifo_level;
    logic                fifo_empty, fifo_not_full, fifo_last;

    assign fifo_wr = s_axis_tvalid && fifo_not_full && enable && !fifo_flush;

    dac_sched_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (fifo_flush),
        .wr_en        (fifo_wr),
        .wr_data      ({s_axis_tlast, s_axis_tdata}),
        .rd_en        (fifo_rd),
        .rd_data      (fifo_rdata),
        .level        (fifo_level),
        .empty        (fifo_empty),
        .not_full     (fifo_not_full),
        .last_present (fifo_last)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        tail_d      = tail_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !m_axis_tready;
        underrun_d  = 1'b0;
        late_d      = 1'b0;
        urun_cnt_d  = urun_cnt_q;
        fifo_rd     = 1'b0;
        fifo_flush  = 1'b0;
        load        = 1'b0;
        pacing      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        tick        = pacing && (cnt_q == CNT_MAX);
        if (pacing) cnt_d = tick ? '0 : cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (enable && !fifo_empty) state_d = ST_PRIME;
            end
            ST_PRIME: begin
                if (!enable) begin
                    fifo_flush = 1'b1;
                    tail_d     = TAIL_INIT;
                    state_d    = ST_DRAIN;
                end else if (fifo_level >= PRIME_LVL || fifo_last) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    fifo_flush = 1'b1;
                    tail_d     = TAIL_INIT;
                    state_d    = ST_DRAIN;
                end else if (tick) begin
                    load = 1'b1;
                    if (!fifo_empty) begin
                        fifo_rd    = 1'b1;
                        out_data_d = to_dac_code(fifo_rdata[15:0]);
                        if (fifo_rdata[ENTRY_W-1]) begin
                            tail_d  = TAIL_INIT;
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        out_data_d = IDLE_CODE;
                        underrun_d = 1'b1;
                        if (urun_cnt_q != '1) urun_cnt_d = urun_cnt_q + 16'd1;
                    end
                end
            end
            default: begin
                if (tick) begin
                    load       = 1'b1;
                    out_data_d = IDLE_CODE;
                    tail_d     = tail_q - 1'b1;
                    if (tail_q == TW'(1)) state_d = ST_IDLE;
                end
            end
        endcase

        // A tick while the previous word is still unaccepted replaces it.
        if (load) begin
            out_valid_d = 1'b1;
            late_d      = out_valid_q && !m_axis_tready;
        end

        // Key held until the final tail word has left the output register.
        ptt_d = (state_q != ST_IDLE) || (ptt_q && out_valid_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tail_q      <= '0;
            out_data_q  <= IDLE_CODE;
            out_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
            late_q      <= 1'b0;
            urun_cnt_q  <= '0;
            ptt_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tail_q      <= tail_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            underrun_q  <= underrun_d;
            late_q      <= late_d;
            urun_cnt_q  <= urun_cnt_d;
            ptt_q       <= ptt_d;
        end
    end

    assign s_axis_tready  = fifo_not_full;
    assign m_axis_tdata   = out_data_q;
    assign m_axis_tvalid  = out_valid_q;
    assign ptt            = ptt_q;
    assign underrun_pulse = underrun_q;
    assign late_pulse     = late_q;
    assign underrun_count = urun_cnt_q;
    assign state_o        = state_q;

endmodule
